buffer_flow_ctrl: RTL and testbench

Control unit that sequences the parallel-read/parallel-write FIFO buffer datapath of the PE input and filter buffers. It turns upstream and downstream valid/ready handshakes into the datapath strobes wen, wcnten, read_en and rcnten, using the datapath's ready, valid, full and empty status. It also keeps a word-occupancy count and provides a drain (flush) sequence used between convolution windows.

---
 rtl/buffer_flow_ctrl.sv | 119 +++++++++++
 tb/tb_buffer_flow_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_flow_ctrl.sv
// Flow controller for the PE input/filter FIFO datapath.
// Turns valid/ready handshakes into write/read strobes, tracks occupancy and sequences drains.
module buffer_flow_ctrl #(
   parameter int DEPTH     = 16,
   parameter int PAR_WRITE = 1,
   parameter int PAR_READ  = 1,
   parameter int OCC_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             flush_req,
   output logic             flush_done,
   input  logic             buf_ready,
   input  logic             buf_valid,
   input  logic             buf_full,
   input  logic             buf_empty,
   output logic             wen,
   output logic             wcnten,
   output logic             read_en,
   output logic             rcnten,
   output logic [OCC_W-1:0] occupancy,
   output logic             overflow_err,
   output logic             underflow_err
);

   localparam int SUM_W = OCC_W + 2;
   localparam logic [SUM_W-1:0] PW_W    = SUM_W'(PAR_WRITE);
   localparam logic [SUM_W-1:0] PR_W    = SUM_W'(PAR_READ);
   localparam logic [SUM_W-1:0] DEPTH_W = SUM_W'(DEPTH);

   typedef enum logic {W_ACCEPT, W_DRAIN} wstate_t;
   typedef enum logic {R_IDLE, R_HOLD} rstate_t;

   wstate_t          wstate;
   rstate_t          rstate;
   logic             write_beat;
   logic             read_beat;
   logic             drain_exit;
   logic             read_short;
   logic [SUM_W-1:0] occ_sum;
   logic [SUM_W-1:0] occ_next;

   // Strobes are combinational and forced low while reset is held so nothing leaks mid-abort.
   always_comb begin
      in_ready   = ~rst & (wstate == W_ACCEPT) & buf_ready & ~buf_full;
      write_beat = in_valid & in_ready;
      if (rstate == R_IDLE)
         read_beat = ~rst & buf_valid;
      else
         read_beat = ~rst & out_ready & buf_valid;
      wen        = write_beat;
      wcnten     = write_beat;
      read_en    = read_beat;
      rcnten     = read_beat;
      drain_exit = (wstate == W_DRAIN) && (occupancy == '0) && (rstate == R_IDLE);

      occ_sum    = {2'b00, occupancy} + (write_beat ? PW_W : '0);
      read_short = read_beat && (occ_sum < PR_W);
      occ_next   = occ_sum;
      if (read_beat)
         occ_next = read_short ? '0 : occ_sum - PR_W;
      if (occ_next > DEPTH_W)
         occ_next = DEPTH_W;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate     <= W_ACCEPT;
         flush_done <= 1'b0;
      end else begin
         flush_done <= drain_exit;
         if (wstate == W_ACCEPT) begin
            if (flush_req)
               wstate <= W_DRAIN;
         end else if (drain_exit) begin
            wstate <= W_ACCEPT;
         end
      end
   end

   // out_valid mirrors R_HOLD; the beat fetched by read_en is held until consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rstate    <= R_IDLE;
         out_valid <= 1'b0;
      end else if (rstate == R_IDLE) begin
         if (read_beat) begin
            rstate    <= R_HOLD;
            out_valid <= 1'b1;
         end
      end else if (out_ready && !read_beat) begin
         rstate    <= R_IDLE;
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy     <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         occupancy <= OCC_W'(occ_next);
         if (write_beat && !buf_ready)
            overflow_err <= 1'b1;
         if (read_short)
            underflow_err <= 1'b1;
      end
   end

   // buf_empty is informational only; gating relies on buf_ready/buf_valid.
   logic unused_ok;
   assign unused_ok = buf_empty;

endmodule

// File: tb/tb_buffer_flow_ctrl.sv
// Table-driven bench for buffer_flow_ctrl: a PAR_WRITE=2/PAR_READ=4 instance on a
// word-count datapath model plus a PAR=1 instance driven directly for concurrency and underflow.
module tb_buffer_flow_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Instance A: DEPTH=16, PAR_WRITE=2, PAR_READ=4
   logic       a_in_valid = 0, a_out_ready = 0, a_flush_req = 0;
   logic       a_in_ready, a_out_valid, a_flush_done;
   logic       a_buf_ready, a_buf_valid, a_buf_full, a_buf_empty;
   logic       a_wen, a_wcnten, a_read_en, a_rcnten, a_ovf, a_unf;
   logic [4:0] a_occ;
   int         dp_cnt;

   buffer_flow_ctrl #(.DEPTH(16), .PAR_WRITE(2), .PAR_READ(4)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .flush_req(a_flush_req), .flush_done(a_flush_done),
      .buf_ready(a_buf_ready), .buf_valid(a_buf_valid),
      .buf_full(a_buf_full), .buf_empty(a_buf_empty),
      .wen(a_wen), .wcnten(a_wcnten), .read_en(a_read_en), .rcnten(a_rcnten),
      .occupancy(a_occ), .overflow_err(a_ovf), .underflow_err(a_unf)
   );

   // Datapath stand-in: counts stored words, reset by the shared rst.
   always @(posedge clk or posedge rst) begin
      if (rst)
         dp_cnt <= 0;
      else
         dp_cnt <= dp_cnt + (a_wen ? 2 : 0) - (a_read_en ? 4 : 0);
   end
   assign a_buf_ready = (dp_cnt + 2 <= 16);
   assign a_buf_valid = (dp_cnt >= 4);
   assign a_buf_full  = (dp_cnt == 16);
   assign a_buf_empty = (dp_cnt == 0);

   // Instance B: DEPTH=16, PAR_WRITE=PAR_READ=1, status driven by hand
   logic       b_in_valid = 0, b_out_ready = 0, b_flush_req = 0;
   logic       b_buf_ready = 0, b_buf_valid = 0, b_buf_full = 0, b_buf_empty = 1;
   logic       b_in_ready, b_out_valid, b_flush_done;
   logic       b_wen, b_wcnten, b_read_en, b_rcnten, b_ovf, b_unf;
   logic [4:0] b_occ;

   buffer_flow_ctrl #(.DEPTH(16), .PAR_WRITE(1), .PAR_READ(1)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .flush_req(b_flush_req), .flush_done(b_flush_done),
      .buf_ready(b_buf_ready), .buf_valid(b_buf_valid),
      .buf_full(b_buf_full), .buf_empty(b_buf_empty),
      .wen(b_wen), .wcnten(b_wcnten), .read_en(b_read_en), .rcnten(b_rcnten),
      .occupancy(b_occ), .overflow_err(b_ovf), .underflow_err(b_unf)
   );

   typedef struct {
      bit in_valid, out_ready, flush_req;
      bit exp_in_ready, exp_wen, exp_read_en, exp_out_valid;
      int exp_occ;
      bit exp_flush_done;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic addVec(input bit iv, input bit ordy, input bit fl, input bit ir, input bit w,
                         input bit re, input bit ov, input int occ, input bit fd);
      vec_t v;
      v.in_valid = iv; v.out_ready = ordy; v.flush_req = fl;
      v.exp_in_ready = ir; v.exp_wen = w; v.exp_read_en = re; v.exp_out_valid = ov;
      v.exp_occ = occ; v.exp_flush_done = fd;
      vecs.push_back(v);
   endtask

   // Drive one cycle's inputs after the falling edge, then check the pre-edge outputs.
   task automatic applyStimulus(input int idx, input vec_t v);
      @(negedge clk);
      a_in_valid = v.in_valid; a_out_ready = v.out_ready; a_flush_req = v.flush_req;
      #1;
      checkOutput($sformatf("row%0d in_ready", idx), int'(a_in_ready), int'(v.exp_in_ready));
      checkOutput($sformatf("row%0d wen", idx), int'(a_wen), int'(v.exp_wen));
      checkOutput($sformatf("row%0d wcnten", idx), int'(a_wcnten), int'(v.exp_wen));
      checkOutput($sformatf("row%0d read_en", idx), int'(a_read_en), int'(v.exp_read_en));
      checkOutput($sformatf("row%0d rcnten", idx), int'(a_rcnten), int'(v.exp_read_en));
      checkOutput($sformatf("row%0d out_valid", idx), int'(a_out_valid), int'(v.exp_out_valid));
      checkOutput($sformatf("row%0d occupancy", idx), int'(a_occ), v.exp_occ);
      checkOutput($sformatf("row%0d flush_done", idx), int'(a_flush_done), int'(v.exp_flush_done));
   endtask

   // Occupancy must track the datapath's full/empty flags.
   always @(negedge clk) begin
      if (!rst && a_buf_full)
         checkOutput("assert occ==DEPTH on full", int'(a_occ), 16);
      if (!rst && a_buf_empty)
         checkOutput("assert occ==0 on empty", int'(a_occ), 0);
   end

   initial begin
      // Fill with out_ready=0: the first 4 words are prefetched into the output stage.
      //     iv or fl  ir wen ren ov occ fd
      addVec(1, 0, 0, 1, 1, 0, 0,  0, 0);
      addVec(1, 0, 0, 1, 1, 0, 0,  2, 0);
      addVec(1, 0, 0, 1, 1, 1, 0,  4, 0);
      addVec(1, 0, 0, 1, 1, 0, 1,  2, 0);
      addVec(1, 0, 0, 1, 1, 0, 1,  4, 0);
      addVec(1, 0, 0, 1, 1, 0, 1,  6, 0);
      addVec(1, 0, 0, 1, 1, 0, 1,  8, 0);
      addVec(1, 0, 0, 1, 1, 0, 1, 10, 0);
      addVec(1, 0, 0, 1, 1, 0, 1, 12, 0);
      addVec(1, 0, 0, 1, 1, 0, 1, 14, 0);
      addVec(1, 0, 0, 0, 0, 0, 1, 16, 0);
      // Streaming read, back-to-back beats
      addVec(0, 1, 0, 0, 0, 1, 1, 16, 0);
      addVec(0, 1, 0, 1, 0, 1, 1, 12, 0);
      addVec(0, 1, 0, 1, 0, 1, 1,  8, 0);
      addVec(0, 1, 0, 1, 0, 1, 1,  4, 0);
      addVec(0, 1, 0, 1, 0, 0, 1,  0, 0);
      addVec(0, 1, 0, 1, 0, 0, 0,  0, 0);
      // Backpressure: refill to 8, then out_ready 1,0,0,1
      addVec(1, 0, 0, 1, 1, 0, 0,  0, 0);
      addVec(1, 0, 0, 1, 1, 0, 0,  2, 0);
      addVec(1, 0, 0, 1, 1, 1, 0,  4, 0);
      addVec(1, 0, 0, 1, 1, 0, 1,  2, 0);
      addVec(1, 0, 0, 1, 1, 0, 1,  4, 0);
      addVec(1, 0, 0, 1, 1, 0, 1,  6, 0);
      addVec(0, 1, 0, 1, 0, 1, 1,  8, 0);
      addVec(0, 0, 0, 1, 0, 0, 1,  4, 0);
      addVec(0, 0, 0, 1, 0, 0, 1,  4, 0);
      addVec(0, 1, 0, 1, 0, 1, 1,  4, 0);
      addVec(0, 1, 0, 1, 0, 0, 1,  0, 0);
      addVec(0, 0, 0, 1, 0, 0, 0,  0, 0);
      // Drain: write taken alongside flush_req, then writes blocked until empty and idle
      addVec(1, 0, 0, 1, 1, 0, 0,  0, 0);
      addVec(1, 0, 0, 1, 1, 0, 0,  2, 0);
      addVec(1, 0, 0, 1, 1, 1, 0,  4, 0);
      addVec(1, 0, 0, 1, 1, 0, 1,  2, 0);
      addVec(1, 0, 0, 1, 1, 0, 1,  4, 0);
      addVec(1, 0, 1, 1, 1, 0, 1,  6, 0);
      addVec(1, 1, 0, 0, 0, 1, 1,  8, 0);
      addVec(1, 1, 1, 0, 0, 1, 1,  4, 0);
      addVec(1, 1, 0, 0, 0, 0, 1,  0, 0);
      addVec(1, 1, 0, 0, 0, 0, 0,  0, 0);
      addVec(1, 1, 0, 1, 1, 0, 0,  0, 1);
      addVec(1, 1, 0, 1, 1, 0, 0,  2, 0);

      // Reset state while rst is held (buffer model would otherwise allow writes)
      repeat (2) @(negedge clk);
      a_in_valid = 1;
      #1;
      checkOutput("reset in_ready", int'(a_in_ready), 0);
      checkOutput("reset wen", int'(a_wen), 0);
      checkOutput("reset out_valid", int'(a_out_valid), 0);
      checkOutput("reset occupancy", int'(a_occ), 0);
      checkOutput("reset flush_done", int'(a_flush_done), 0);
      a_in_valid = 0;
      rst = 0;

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(i, vecs[i]);

      checkOutput("overflow_err clear", int'(a_ovf), 0);
      checkOutput("underflow_err clear", int'(a_unf), 0);

      // Asynchronous reset mid-stream, with a write and a read both pending
      @(negedge clk);
      a_in_valid = 1; a_out_ready = 0;
      #1;
      checkOutput("pre-reset occupancy", int'(a_occ), 4);
      checkOutput("pre-reset wen", int'(a_wen), 1);
      checkOutput("pre-reset read_en", int'(a_read_en), 1);
      rst = 1;
      #1;
      checkOutput("async reset occupancy", int'(a_occ), 0);
      checkOutput("async reset in_ready", int'(a_in_ready), 0);
      checkOutput("async reset wen", int'(a_wen), 0);
      checkOutput("async reset wcnten", int'(a_wcnten), 0);
      checkOutput("async reset read_en", int'(a_read_en), 0);
      checkOutput("async reset rcnten", int'(a_rcnten), 0);
      checkOutput("async reset out_valid", int'(a_out_valid), 0);
      checkOutput("async reset flush_done", int'(a_flush_done), 0);
      checkOutput("async reset overflow_err", int'(a_ovf), 0);
      checkOutput("async reset underflow_err", int'(a_unf), 0);
      a_in_valid = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      #1;
      checkOutput("post-reset out_valid", int'(a_out_valid), 0);
      checkOutput("post-reset occupancy", int'(a_occ), 0);

      // Instance B: concurrent write and read hold occupancy at 5
      @(negedge clk);
      b_buf_ready = 1; b_buf_empty = 0; b_in_valid = 1;
      repeat (5) @(negedge clk);
      b_buf_valid = 1; b_out_ready = 1;
      #1;
      checkOutput("b occ after 5 writes", int'(b_occ), 5);
      checkOutput("b concurrent wen idle", int'(b_wen), 1);
      checkOutput("b concurrent read_en idle", int'(b_read_en), 1);
      @(negedge clk);
      #1;
      checkOutput("b occ after concurrent 1", int'(b_occ), 5);
      checkOutput("b out_valid", int'(b_out_valid), 1);
      checkOutput("b concurrent wen hold", int'(b_wen), 1);
      checkOutput("b concurrent read_en hold", int'(b_read_en), 1);
      @(negedge clk);
      b_in_valid = 0;
      #1;
      checkOutput("b occ after concurrent 2", int'(b_occ), 5);

      // Five reads empty it; a sixth strobe from 0 trips the sticky underflow flag
      repeat (5) @(negedge clk);
      #1;
      checkOutput("b occ drained", int'(b_occ), 0);
      checkOutput("b underflow before", int'(b_unf), 0);
      @(negedge clk);
      b_buf_valid = 0;
      #1;
      checkOutput("b underflow after", int'(b_unf), 1);
      checkOutput("b occ saturated at 0", int'(b_occ), 0);
      repeat (3) @(negedge clk);
      checkOutput("b underflow sticky", int'(b_unf), 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
